// File: rtl/hist_eq_map_if.sv
// Bundle for the histogram-equalisation mapper: CDF load stream, incoming video and equalised video.
// The master side drives the CDF load stream and the incoming pixels; the slave side is the mapper.
interface hist_eq_map_if;
   logic [7:0]  pixel_level_data;
   logic [20:0] pixel_cnt_num;
   logic        pixel_level_vld;
   logic        pre_img_vsync;
   logic        pre_img_hsync;
   logic        pre_img_valid;
   logic [7:0]  pre_img_gray;
   logic        post_img_vsync;
   logic        post_img_hsync;
   logic        post_img_valid;
   logic [7:0]  post_img_gray;
   logic        lut_ready;

   modport master (
      output pixel_level_data, pixel_cnt_num, pixel_level_vld,
      output pre_img_vsync, pre_img_hsync, pre_img_valid, pre_img_gray,
      input  post_img_vsync, post_img_hsync, post_img_valid, post_img_gray, lut_ready
   );

   modport slave (
      input  pixel_level_data, pixel_cnt_num, pixel_level_vld,
      input  pre_img_vsync, pre_img_hsync, pre_img_valid, pre_img_gray,
      output post_img_vsync, post_img_hsync, post_img_valid, post_img_gray, lut_ready
   );
endinterface

// File: rtl/hist_eq_map.sv
// Histogram-equalisation mapper: converts a streamed CDF into a 256-entry gray LUT and remaps video.
// Define HIST_EQ_DBUF_EN for a double-buffered LUT that swaps only at the vsync falling edge.
module hist_eq_map #(
   parameter logic [10:0] H_DISP = 11'd800,
   parameter logic [10:0] V_DISP = 11'd600
) (
   input logic          clk,
   input logic          rst_n,
   hist_eq_map_if.slave bus
);

   localparam logic [63:0] N_PIX   = 64'(H_DISP) * 64'(V_DISP);
   localparam logic [63:0] RECIP64 = ((64'd255 << 24) + (N_PIX >> 1)) / N_PIX;
   localparam logic [31:0] RECIP   = RECIP64[31:0];
   localparam logic [52:0] ROUND   = 53'd1 << 23;

   typedef enum logic [1:0] {IDLE, LOAD, DONE} load_state_e;

   // CDF -> gray level, full-width product so large counts saturate instead of wrapping
   logic [52:0] map_prod;
   logic [28:0] map_q;
   logic [7:0]  map_val;

   assign map_prod = 53'(bus.pixel_cnt_num) * 53'(RECIP);
   assign map_q    = 29'((map_prod + ROUND) >> 24);
   assign map_val  = (map_q > 29'd255) ? 8'hFF : map_q[7:0];

   load_state_e state, state_nxt;
   logic        lut_we;
   logic        table_done;

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_nxt  = state;
      lut_we     = 1'b0;
      table_done = 1'b0;
      case (state)
         IDLE: begin
            if (bus.pixel_level_vld && bus.pixel_level_data == 8'd0) begin
               lut_we    = 1'b1;
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            if (bus.pixel_level_vld) begin
               lut_we = 1'b1;
               if (bus.pixel_level_data == 8'hFF) begin
                  table_done = 1'b1;
                  state_nxt  = DONE;
               end
            end else begin
               state_nxt = IDLE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   logic vs_d1, vs_d2;
   logic lut_ready;
   logic [7:0] rd_data;

`ifdef HIST_EQ_DBUF_EN
   logic [7:0] lut_a [256];
   logic [7:0] lut_b [256];
   logic       active_bank;
   logic       table_pending;
   logic       swap;

   // A new table is only swapped in on the vsync falling edge, never mid-frame
   assign swap = vs_d2 & ~vs_d1 & table_pending;

   // NOTE: LUT storage has no reset; its contents are only used once a complete table is active.
   always_ff @(posedge clk) begin
      if (lut_we) begin
         if (active_bank) lut_a[bus.pixel_level_data] <= map_val;
         else             lut_b[bus.pixel_level_data] <= map_val;
      end
      rd_data <= active_bank ? lut_b[bus.pre_img_gray] : lut_a[bus.pre_img_gray];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_bank   <= 1'b0;
         table_pending <= 1'b0;
         lut_ready     <= 1'b0;
      end else begin
         if (swap) begin
            active_bank <= ~active_bank;
            lut_ready   <= 1'b1;
         end
         table_pending <= table_done | (table_pending & ~swap);
      end
   end
`else
   logic [7:0] lut [256];

   always_ff @(posedge clk) begin
      if (lut_we) lut[bus.pixel_level_data] <= map_val;
      rd_data <= lut[bus.pre_img_gray];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lut_ready <= 1'b0;
      else        lut_ready <= lut_ready | table_done;
   end
`endif

   logic       hs_d1, val_d1, use_lut_d1;
   logic [7:0] gray_d1;
   logic       post_hsync, post_valid;
   logic [7:0] post_gray;

   // Stage 1 runs alongside the LUT read; stage 2 is the output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_d1      <= 1'b0;
         hs_d1      <= 1'b0;
         val_d1     <= 1'b0;
         gray_d1    <= 8'd0;
         use_lut_d1 <= 1'b0;
         vs_d2      <= 1'b0;
         post_hsync <= 1'b0;
         post_valid <= 1'b0;
         post_gray  <= 8'd0;
      end else begin
         vs_d1      <= bus.pre_img_vsync;
         hs_d1      <= bus.pre_img_hsync;
         val_d1     <= bus.pre_img_valid;
         gray_d1    <= bus.pre_img_gray;
         use_lut_d1 <= lut_ready;
         vs_d2      <= vs_d1;
         post_hsync <= hs_d1;
         post_valid <= val_d1;
         post_gray  <= !val_d1 ? 8'd0 : (use_lut_d1 ? rd_data : gray_d1);
      end
   end

   assign bus.post_img_vsync = vs_d2;
   assign bus.post_img_hsync = post_hsync;
   assign bus.post_img_valid = post_valid;
   assign bus.post_img_gray  = post_gray;
   assign bus.lut_ready      = lut_ready;

endmodule
